pixel_addr_gen: RTL

Row/column RAM address generator answering the 5-bit counter control codes issued by the pixel processing FSMs. It holds a row base counter and a column base counter. Each cycle it decodes the row and column codes into reset, commit-step or temporary-offset actions. It drives a registered, row-major frame-RAM address plus per-axis overflow flags back to the controlling FSM. It sits between the processing FSM and the frame RAM address port, one instance per RAM.

---
 rtl/pixel_addr_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: row/column base counters driven by 5-bit control codes,
// producing a registered row-major frame-RAM address plus overflow/clamp flags.

// One counter axis: holds base and overflow, computes next effective index.
module pixel_addr_gen_axis #(
  parameter int N = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_ctrl,
  output logic [4:0] o_eff_d,
  output logic       o_clamp_d,
  output logic       o_ovf
);
  localparam logic [5:0] N6   = 6'(N);
  localparam logic [5:0] NM16 = 6'(N - 1);

  logic [4:0] base_q, base_d;
  logic       ovf_q, ovf_d;
  logic [5:0] sum;

  // Decode control: RESET beats ENABLE beats offset read.
  always_comb begin
    sum       = {1'b0, base_q} + {3'b000, i_ctrl[2:0]};
    base_d    = base_q;
    ovf_d     = ovf_q;
    o_eff_d   = base_q;
    o_clamp_d = 1'b0;
    if (i_ctrl[4]) begin
      base_d  = '0;
      ovf_d   = 1'b0;
      o_eff_d = '0;
    end else if (i_ctrl[3]) begin
      if (sum >= N6) begin
        base_d = 5'(sum - N6);
        ovf_d  = 1'b1;
      end else begin
        base_d = sum[4:0];
        ovf_d  = 1'b0;
      end
      o_eff_d = base_d;
    end else if (sum > NM16) begin
      // Offset past the last index saturates; base is left untouched.
      o_eff_d   = NM16[4:0];
      o_clamp_d = 1'b1;
    end else begin
      o_eff_d = sum[4:0];
    end
  end

  // Base and overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      base_q <= base_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_ovf = ovf_q;
endmodule

module pixel_addr_gen #(
  parameter int PIXEL_N_COLS = 24,
  parameter int PIXEL_N_ROWS = 24,
  parameter int NB_ADDR      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         i_row_control,
  input  logic [4:0]         i_col_control,
  output logic               o_row_overflow,
  output logic               o_col_overflow,
  output logic [4:0]         o_row_idx,
  output logic [4:0]         o_col_idx,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic               o_addr_err
);
  logic [4:0]         row_eff_d, col_eff_d;
  logic               row_clamp_d, col_clamp_d;
  logic [4:0]         row_idx_q, col_idx_q;
  logic [NB_ADDR-1:0] ram_addr_q, ram_addr_d;
  logic               addr_err_q, addr_err_d;

  pixel_addr_gen_axis #(.N(PIXEL_N_ROWS)) u_row (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ctrl    (i_row_control),
    .o_eff_d   (row_eff_d),
    .o_clamp_d (row_clamp_d),
    .o_ovf     (o_row_overflow)
  );

  pixel_addr_gen_axis #(.N(PIXEL_N_COLS)) u_col (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ctrl    (i_col_control),
    .o_eff_d   (col_eff_d),
    .o_clamp_d (col_clamp_d),
    .o_ovf     (o_col_overflow)
  );

  // Address is formed from next-state indices so it lines up with them.
  always_comb begin
    ram_addr_d = NB_ADDR'(row_eff_d) * NB_ADDR'(PIXEL_N_COLS) + NB_ADDR'(col_eff_d);
    addr_err_d = row_clamp_d | col_clamp_d;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_q  <= '0;
      col_idx_q  <= '0;
      ram_addr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      row_idx_q  <= row_eff_d;
      col_idx_q  <= col_eff_d;
      ram_addr_q <= ram_addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign o_row_idx  = row_idx_q;
  assign o_col_idx  = col_idx_q;
  assign o_ram_addr = ram_addr_q;
  assign o_addr_err = addr_err_q;
endmodule
